alu_share_ctrl: RTL and testbench

//  Shares one WIDTH-bit OPq ALU (add/sub/and/xor) between two requesters (0,1) with round-robin arbitration.

---
 rtl/alu_share_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_share_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: one shared WIDTH-bit ALU (add/sub/and/xor) serving two
// requesters under round-robin arbitration. Each op runs IDLE -> EXEC -> RESP.
// A result is registered together with its {ZF,SF,OF} condition codes and
// the id of the requester that owns it.
// Ports:
//   clk, rst_n                 clock; synchronous active-low reset
//   reqN_valid/ready           request handshake (N = 0,1); ready is only
//                              raised in IDLE, and only for the granted side
//   reqN_fn/a/b                op code (0 add, 1 sub, 2 and, 3 xor) and operands
//   resp_valid/ready           response handshake
//   resp_id/data/cc/err        owner id, result, {ZF,SF,OF}, illegal-op flag
module alu_share_ctrl #(
  parameter int WIDTH     = 64,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_fn,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_fn,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic [2:0]       resp_cc,
  output logic             resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           r_state;
  logic             r_prio;
  logic [3:0]       r_fn;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_id;
  logic             r_resp_valid, r_resp_id, r_resp_err;
  logic [WIDTH-1:0] r_resp_data;
  logic [2:0]       r_resp_cc;

  // Grant: a lone requester wins outright; on contention the priority holder wins.
  logic w_gnt, w_idle, w_hs;
  assign w_gnt      = (req0_valid && req1_valid) ? r_prio : req1_valid;
  assign w_idle     = rst_n && (r_state == S_IDLE);
  assign req0_ready = w_idle && req0_valid && !w_gnt;
  assign req1_ready = w_idle && req1_valid &&  w_gnt;
  assign w_hs       = req0_ready || req1_ready;

  // ALU on the latched operands.
  logic [WIDTH-1:0] w_res;
  logic             w_of, w_err;
  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    w_err = 1'b0;
    case (r_fn)
      4'd0: begin
        w_res = r_a + r_b;
        w_of  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
      end
      4'd1: begin
        w_res = r_a - r_b;
        w_of  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
      end
      4'd2:    w_res = r_a & r_b;
      4'd3:    w_res = r_a ^ r_b;
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_prio       <= INIT_PRIO;
      r_fn         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_data  <= '0;
      r_resp_cc    <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_hs) begin
          r_fn    <= w_gnt ? req1_fn : req0_fn;
          r_a     <= w_gnt ? req1_a  : req0_a;
          r_b     <= w_gnt ? req1_b  : req0_b;
          r_id    <= w_gnt;
          r_prio  <= !w_gnt;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_resp_valid <= 1'b1;
          r_resp_id    <= r_id;
          r_resp_err   <= w_err;
          // Illegal ops report zero data and zero flags.
          r_resp_data  <= w_err ? '0 : w_res;
          r_resp_cc    <= w_err ? 3'b000 : {(w_res == '0), w_res[WIDTH-1], w_of};
          r_state      <= S_RESP;
        end
        S_RESP: if (resp_ready) begin
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign resp_cc    = r_resp_cc;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: reset, arithmetic/flags, round-robin
// contention, response back-pressure, illegal op and reset mid-op.
module tb_alu_share_ctrl;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_fn = '0, req1_fn = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         resp_valid, resp_ready = 1'b0, resp_id, resp_err;
  logic [W-1:0] resp_data;
  logic [2:0]   resp_cc;

  int n_vec = 0;
  int n_err = 0;

  alu_share_ctrl #(.WIDTH(W), .INIT_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fn(req0_fn),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fn(req1_fn),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_cc(resp_cc), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op, confirm acceptance, then confirm resp_valid two cycles later.
  task automatic issue(input bit id, input logic [3:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin req1_fn = fn; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_fn = fn; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    #1;
    chk("issue_ready", id ? req1_ready : req0_ready, 1);
    tick();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    chk("exec_no_valid", resp_valid, 0);
    tick();
    chk("resp_valid_n2", resp_valid, 1);
  endtask

  task automatic retire();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("retired", resp_valid, 0);
  endtask

  initial begin
    // Reset with requests pending: no ready, all outputs at reset values.
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick(); tick();
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_cc", resp_cc, 0);
    chk("rst_err", resp_err, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // 1: req0 add 10 + -15 = -5, SF set.
    issue(1'b0, 4'd0, 64'd10, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("t1_id", resp_id, 0);
    chk("t1_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("t1_cc", resp_cc, 3'b010);
    chk("t1_err", resp_err, 0);
    retire();

    // 2: req1 sub min_int - 1 overflows to max_int.
    issue(1'b1, 4'd1, 64'h8000_0000_0000_0000, 64'd1);
    chk("t2_id", resp_id, 1);
    chk("t2_data", resp_data, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("t2_cc", resp_cc, 3'b001);
    retire();

    // 3: both valid every cycle, consumer always ready: grants alternate 0,1,0,1.
    req0_fn = 4'd0; req0_a = 64'd1; req0_b = 64'd1;
    req1_fn = 4'd3; req1_a = 64'd5; req1_b = 64'd3;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      chk("t3_rdy0", req0_ready, ((c % 6) == 0) ? 1 : 0);
      chk("t3_rdy1", req1_ready, ((c % 6) == 3) ? 1 : 0);
      chk("t3_rvalid", resp_valid, ((c % 3) == 2) ? 1 : 0);
      if ((c % 3) == 2) begin
        chk("t3_id", resp_id, ((c % 6) == 5) ? 1 : 0);
        chk("t3_data", resp_data, ((c % 6) == 5) ? 64'd6 : 64'd2);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    tick();

    // 4: req0 sub 10-10 with consumer stalled 5 cycles; req1 waits throughout.
    req0_fn = 4'd1; req0_a = 64'd10; req0_b = 64'd10;
    req1_fn = 4'd2; req1_a = 64'hF0; req1_b = 64'h3C;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t4_rdy0", req0_ready, 1);
    chk("t4_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t4_hold_valid", resp_valid, 1);
      chk("t4_hold_data", resp_data, 0);
      chk("t4_hold_cc", resp_cc, 3'b100);
      chk("t4_hold_rdy1", req1_ready, 0);
    end
    resp_ready = 1'b1;
    #1;
    chk("t4_release_rdy1", req1_ready, 0);
    tick();
    resp_ready = 1'b0;
    chk("t4_idle_valid", resp_valid, 0);
    chk("t4_idle_rdy1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("t4_r1_valid", resp_valid, 1);
    chk("t4_r1_id", resp_id, 1);
    chk("t4_r1_data", resp_data, 64'h30);
    chk("t4_r1_cc", resp_cc, 3'b000);
    retire();

    // 5: illegal fn, then a normal add clears the error.
    issue(1'b0, 4'd7, 64'd5, 64'd9);
    chk("t5_err", resp_err, 1);
    chk("t5_data", resp_data, 0);
    chk("t5_cc", resp_cc, 0);
    retire();
    issue(1'b0, 4'd0, 64'd1, 64'd2);
    chk("t5b_err", resp_err, 0);
    chk("t5b_data", resp_data, 64'd3);
    chk("t5b_cc", resp_cc, 0);
    retire();

    // 6: reset during EXEC drops the op and restores priority to requester 0
    // (priority before the reset belongs to requester 1).
    req0_fn = 4'd0; req0_a = 64'd7; req0_b = 64'd8; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk("t6_rst_rdy0", req0_ready, 0);
    tick();
    chk("t6_valid", resp_valid, 0);
    chk("t6_data", resp_data, 0);
    rst_n = 1'b1;
    req0_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t6_no_stale", resp_valid, 0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_fn = 4'd3; req0_a = 64'hFF; req0_b = 64'hFF;
    #1;
    chk("t6_prio_rdy0", req0_ready, 1);
    chk("t6_prio_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("t6_x_valid", resp_valid, 1);
    chk("t6_x_data", resp_data, 0);
    chk("t6_x_cc", resp_cc, 3'b100);
    retire();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
